// File: rtl/svc_rv_hazard_ctl.sv
// Hazard control: load-use stall, redirect flush, DIV/REM freeze, watchdog.
// Define SVC_RV_HAZARD_STATS_EN to add stall_cycles/flush_events counters.
module svc_rv_hazard_ctl #(
  parameter int XLEN       = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic [4:0] rd_ex,
  input  logic       mem_read_ex,
  input  logic       valid_ex,
  input  logic       is_mc_ex,
  input  logic       mc_done,
  input  logic       redirect_ex,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       mc_start,
  output logic       mc_timeout
`ifdef SVC_RV_HAZARD_STATS_EN
  ,
  output logic [XLEN-1:0] stall_cycles,
  output logic [XLEN-1:0] flush_events
`endif
);

  localparam int CW = $clog2(MC_TIMEOUT);

  if (MC_TIMEOUT < 2 || MC_TIMEOUT > 1023 ||
      XLEN < 1) begin : g_bad_cfg
    $error("svc_rv_hazard_ctl: bad parameters");
  end

  typedef enum logic {
    S_IDLE,
    S_MC_BUSY
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_timeout;

  logic w_mc_hit;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_wd_fire;

  assign w_mc_hit   = valid_ex & is_mc_ex;
  assign w_rs1_hit  = rs1_used_id & (rs1_id == rd_ex);
  assign w_rs2_hit  = rs2_used_id & (rs2_id == rd_ex);
  assign w_load_use = valid_ex & mem_read_ex &
                      (rd_ex != 5'd0) &
                      (w_rs1_hit | w_rs2_hit);

  // mc_done on the terminal count wins over the watchdog
  assign w_wd_fire = (r_state == S_MC_BUSY) & ~mc_done &
                     (r_cnt == CW'(MC_TIMEOUT - 1));

  assign mc_timeout = r_timeout;

  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    mc_start    = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mc_hit) begin
            mc_start    = 1'b1;
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
          end else if (redirect_ex) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        S_MC_BUSY: begin
          if (!mc_done && !w_wd_fire) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_stall = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_mc_hit) begin
            r_state <= S_MC_BUSY;
            r_cnt   <= '0;
          end
        end
        S_MC_BUSY: begin
          if (mc_done) begin
            r_state <= S_IDLE;
          end else if (w_wd_fire) begin
            r_state   <= S_IDLE;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SVC_RV_HAZARD_STATS_EN
  logic [XLEN-1:0] r_stall_cycles;
  logic [XLEN-1:0] r_flush_events;

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (pc_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (id_ex_flush && (r_flush_events != '1))
        r_flush_events <= r_flush_events + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_svc_rv_hazard_ctl.sv
// Directed-vector bench for svc_rv_hazard_ctl (MC_TIMEOUT=8).
// Output vector: pc_st,ifid_st,ifid_fl,idex_st,idex_fl,start,timeout.
module tb_svc_rv_hazard_ctl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       rs1_used_id;
  logic       rs2_used_id;
  logic [4:0] rd_ex;
  logic       mem_read_ex;
  logic       valid_ex;
  logic       is_mc_ex;
  logic       mc_done;
  logic       redirect_ex;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_stall;
  logic       id_ex_flush;
  logic       mc_start;
  logic       mc_timeout;
`ifdef SVC_RV_HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  always #5 clk = ~clk;

  svc_rv_hazard_ctl #(
    .XLEN       (32),
    .MC_TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs1_used_id (rs1_used_id),
    .rs2_used_id (rs2_used_id),
    .rd_ex       (rd_ex),
    .mem_read_ex (mem_read_ex),
    .valid_ex    (valid_ex),
    .is_mc_ex    (is_mc_ex),
    .mc_done     (mc_done),
    .redirect_ex (redirect_ex),
    .pc_stall    (pc_stall),
    .if_id_stall (if_id_stall),
    .if_id_flush (if_id_flush),
    .id_ex_stall (id_ex_stall),
    .id_ex_flush (id_ex_flush),
    .mc_start    (mc_start),
    .mc_timeout  (mc_timeout)
`ifdef SVC_RV_HAZARD_STATS_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
`endif
  );

  localparam logic [6:0] ZERO = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] MCS  = 7'b1101010;
  localparam logic [6:0] BUSY = 7'b1101000;
  localparam logic [6:0] RED  = 7'b0010100;
  localparam logic [6:0] TO   = 7'b0000001;

  logic [6:0] w_out;
  assign w_out = {pc_stall, if_id_stall, if_id_flush,
                  id_ex_stall, id_ex_flush,
                  mc_start, mc_timeout};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rs1_id      = 5'd0;
    rs2_id      = 5'd0;
    rs1_used_id = 1'b0;
    rs2_used_id = 1'b0;
    rd_ex       = 5'd0;
    mem_read_ex = 1'b0;
    valid_ex    = 1'b0;
    is_mc_ex    = 1'b0;
    mc_done     = 1'b0;
    redirect_ex = 1'b0;
  endtask

  task automatic mc_in();
    idle_in();
    valid_ex = 1'b1;
    is_mc_ex = 1'b1;
    rd_ex    = 5'd3;
  endtask

  initial begin
    idle_in();
    rst_n       = 1'b0;
    valid_ex    = 1'b1;
    is_mc_ex    = 1'b1;
    redirect_ex = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(w_out), 32'(ZERO));
`ifdef SVC_RV_HAZARD_STATS_EN
    chk("rst_stall_cnt", stall_cycles, 32'd0);
    chk("rst_flush_cnt", flush_events, 32'd0);
`endif
    idle_in();
    rst_n = 1'b1;
    #1 chk("idle", 32'(w_out), 32'(ZERO));

    tick();
    valid_ex    = 1'b1;
    mem_read_ex = 1'b1;
    rd_ex       = 5'd5;
    rs1_id      = 5'd5;
    rs1_used_id = 1'b1;
    #1 chk("lu_rs1", 32'(w_out), 32'(LU));
    tick();
    mem_read_ex = 1'b0;
    rd_ex       = 5'd6;
    #1 chk("lu_bubble", 32'(w_out), 32'(ZERO));

    tick();
    mc_in();
    #1 chk("div_start", 32'(w_out), 32'(MCS));
    for (int i = 0; i < 4; i++) begin
      tick();
      redirect_ex = (i == 1);
      #1 chk("div_busy", 32'(w_out), 32'(BUSY));
    end
    tick();
    redirect_ex = 1'b0;
    mc_done     = 1'b1;
    #1 chk("div_done", 32'(w_out), 32'(ZERO));
    tick();
    idle_in();
    mc_done = 1'b1;
    #1 chk("done_idle", 32'(w_out), 32'(ZERO));
`ifdef SVC_RV_HAZARD_STATS_EN
    chk("stall_cnt", stall_cycles, 32'd6);
    chk("flush_cnt", flush_events, 32'd1);
`endif

    tick();
    idle_in();
    valid_ex    = 1'b1;
    mem_read_ex = 1'b1;
    rd_ex       = 5'd0;
    rs1_id      = 5'd0;
    rs1_used_id = 1'b1;
    #1 chk("lu_x0", 32'(w_out), 32'(ZERO));
    tick();
    rd_ex       = 5'd7;
    rs1_id      = 5'd2;
    rs2_id      = 5'd7;
    rs2_used_id = 1'b1;
    #1 chk("lu_rs2", 32'(w_out), 32'(LU));
    rs2_used_id = 1'b0;
    #1 chk("lu_unused", 32'(w_out), 32'(ZERO));
    rs2_used_id = 1'b1;
    valid_ex    = 1'b0;
    #1 chk("lu_invalid", 32'(w_out), 32'(ZERO));
    tick();
    valid_ex    = 1'b1;
    redirect_ex = 1'b1;
    #1 chk("red_lu", 32'(w_out), 32'(RED));
    tick();
    idle_in();
    #1 chk("post_red", 32'(w_out), 32'(ZERO));

    tick();
    mc_in();
    #1 chk("edge_start", 32'(w_out), 32'(MCS));
    for (int i = 0; i < 7; i++) begin
      tick();
      #1 chk("edge_busy", 32'(w_out), 32'(BUSY));
    end
    tick();
    mc_done = 1'b1;
    #1 chk("edge_done", 32'(w_out), 32'(ZERO));
    tick();
    idle_in();
    #1 chk("edge_no_to", 32'(w_out), 32'(ZERO));

    tick();
    mc_in();
    #1 chk("wd_start", 32'(w_out), 32'(MCS));
    for (int i = 0; i < 7; i++) begin
      tick();
      #1 chk("wd_busy", 32'(w_out), 32'(BUSY));
    end
    tick();
    #1 chk("wd_fire", 32'(w_out), 32'(ZERO));
    tick();
    idle_in();
    #1 chk("wd_set", 32'(w_out), 32'(TO));
    tick();
    #1 chk("wd_sticky", 32'(w_out), 32'(TO));
    tick();
    mc_in();
    #1 chk("wd_restart", 32'(w_out), 32'(MCS | TO));
    tick();
    #1 chk("wd_rbusy", 32'(w_out), 32'(BUSY | TO));
    tick();
    mc_done = 1'b1;
    #1 chk("wd_rdone", 32'(w_out), 32'(TO));
    tick();
    idle_in();
    #1 chk("wd_ridle", 32'(w_out), 32'(TO));

    tick();
    mc_in();
    #1 chk("rb_start", 32'(w_out), 32'(MCS | TO));
    tick();
    #1 chk("rb_busy1", 32'(w_out), 32'(BUSY | TO));
    tick();
    #1 chk("rb_busy2", 32'(w_out), 32'(BUSY | TO));
    #1 rst_n = 1'b0;
    #1 chk("rst_busy", 32'(w_out), 32'(ZERO));
    tick();
    idle_in();
    rst_n = 1'b1;
    #1 chk("rst_release", 32'(w_out), 32'(ZERO));
    tick();
    #1 chk("rst_no_start", 32'(w_out), 32'(ZERO));
    tick();
    mc_in();
    #1 chk("rst_fresh", 32'(w_out), 32'(MCS));
    tick();
    mc_done = 1'b1;
    #1 chk("rst_fdone", 32'(w_out), 32'(ZERO));
    tick();
    idle_in();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
